// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer (slave) and the board/PLL wrapper side (master).
interface pll_lock_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             pll_locked;
  logic             restart;
  logic             pll_rst;
  logic             sys_rst_n;
  logic             ready;
  logic             fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] loss_cnt;
  logic [CNT_W-1:0] tmo_cnt;

  modport master (
    output pll_locked, restart,
    input  pll_rst, sys_rst_n, ready, fault, state, loss_cnt, tmo_cnt
  );

  modport slave (
    input  pll_locked, restart,
    output pll_rst, sys_rst_n, ready, fault, state, loss_cnt, tmo_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL power-up/recovery sequencer on the reference clock: PLL reset pulse, lock wait, debounce, RUN.
// Define PLL_SEQ_STATUS_EN to implement the saturating loss/timeout status counters.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 4,
  parameter int CNT_W         = 8
) (
  input  logic                 refclk_i,
  input  logic                 rst_n_i,
  pll_lock_sequencer_if.slave  seq_if
);

  localparam int TMR_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int TMR_MAX   = (TMR_MAX_A > STABLE_CYCLES) ? TMR_MAX_A : STABLE_CYCLES;
  localparam int TMR_W     = $clog2(TMR_MAX) + 1;
  localparam int RETRY_W   = $clog2(MAX_RETRIES + 1);

  localparam logic [TMR_W-1:0]   RST_LOAD    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TMO_LOAD    = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   STB_LOAD    = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic               lk_meta_q, lk_s_q;
  logic               pll_rst_q, sys_rst_n_q, ready_q, fault_q;
  logic               loss_inc, tmo_inc;

  assign retry_inc = retry_q + 1'b1;

  // Timer counts down to zero; the cycle that sees zero takes the exit transition.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    retry_d  = retry_q;
    loss_inc = 1'b0;
    tmo_inc  = 1'b0;
    if (seq_if.restart) begin
      state_d = S_HOLD;
      timer_d = RST_LOAD;
      retry_d = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (timer_q == '0) begin
            state_d = S_WAIT_LOCK;
            timer_d = TMO_LOAD;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lk_s_q) begin
            state_d = S_STABLE;
            timer_d = STB_LOAD;
          end else if (timer_q == '0) begin
            tmo_inc = 1'b1;
            retry_d = retry_inc;
            if (retry_inc == RETRY_LIMIT) begin
              state_d = S_FAULT;
              timer_d = '0;
            end else begin
              state_d = S_HOLD;
              timer_d = RST_LOAD;
            end
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        S_STABLE: begin
          if (!lk_s_q) begin
            state_d = S_WAIT_LOCK;
            timer_d = TMO_LOAD;
          end else if (timer_q == '0) begin
            state_d = S_RUN;
            timer_d = '0;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        S_RUN: begin
          retry_d = '0;
          if (!lk_s_q) begin
            loss_inc = 1'b1;
            state_d  = S_HOLD;
            timer_d  = RST_LOAD;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_HOLD;
          timer_d = RST_LOAD;
          retry_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as state.
  always_ff @(posedge refclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_HOLD;
      timer_q     <= RST_LOAD;
      retry_q     <= '0;
      lk_meta_q   <= 1'b0;
      lk_s_q      <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      lk_meta_q   <= seq_if.pll_locked;
      lk_s_q      <= lk_meta_q;
      pll_rst_q   <= (state_d == S_HOLD) || (state_d == S_FAULT);
      sys_rst_n_q <= (state_d == S_RUN);
      ready_q     <= (state_d == S_RUN);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign seq_if.pll_rst   = pll_rst_q;
  assign seq_if.sys_rst_n = sys_rst_n_q;
  assign seq_if.ready     = ready_q;
  assign seq_if.fault     = fault_q;
  assign seq_if.state     = state_q;

`ifdef PLL_SEQ_STATUS_EN
  logic [CNT_W-1:0] loss_cnt_q, tmo_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge refclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      loss_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      if (loss_inc) loss_cnt_q <= sat_inc(loss_cnt_q);
      if (tmo_inc)  tmo_cnt_q  <= sat_inc(tmo_cnt_q);
    end
  end

  assign seq_if.loss_cnt = loss_cnt_q;
  assign seq_if.tmo_cnt  = tmo_cnt_q;
`else
  logic unused_status;
  assign unused_status   = loss_inc | tmo_inc;
  assign seq_if.loss_cnt = '0;
  assign seq_if.tmo_cnt  = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: expected per-cycle output snapshots are queued with
// the stimulus and compared when the cycle they describe is reached.
module tb_pll_lock_sequencer;

  localparam int CNT_W = 8;

`ifdef PLL_SEQ_STATUS_EN
  localparam bit STATUS = 1'b1;
`else
  localparam bit STATUS = 1'b0;
`endif

  localparam logic [2:0] HOLD = 3'd0, WAIT = 3'd1, STAB = 3'd2, RUN = 3'd3, FLT = 3'd4;

  typedef struct {
    int          cyc;
    string       tag;
    logic [22:0] v;
  } exp_t;

  logic refclk = 1'b0;
  logic rst_n  = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  pll_lock_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pll_lock_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRIES(2), .CNT_W(CNT_W)
  ) dut (
    .refclk_i(refclk),
    .rst_n_i (rst_n),
    .seq_if  (bus.slave)
  );

  always #10 refclk = ~refclk;

  logic [22:0] obs;
  assign obs = {bus.state, bus.pll_rst, bus.sys_rst_n, bus.ready, bus.fault, bus.loss_cnt, bus.tmo_cnt};

  function automatic logic [7:0] cnt(input int n);
    return STATUS ? 8'(n) : 8'd0;
  endfunction

  function automatic logic [22:0] ex(input logic [2:0] st, input logic p, input logic s,
                                     input logic r, input logic f, input logic [7:0] l,
                                     input logic [7:0] t);
    return {st, p, s, r, f, l, t};
  endfunction

  task automatic push(input int c, input string tag, input logic [22:0] v);
    exp_t e;
    e.cyc = c;
    e.tag = tag;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.pll_locked = 1'b0;
    bus.restart    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    bus.pll_locked = 1'b0;
    bus.restart    = 1'b0;
    tick();
    tick();
    push(0, "reset_values", ex(HOLD, 1, 0, 0, 0, 0, 0));
    e = exp_q.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s got=%h want=%h", e.tag, obs, e.v);
    end
  endtask

  task automatic test_normal_start();
    exp_t e;
    int prst_hi = 0;
    int rise = -1;
    do_reset();
    push(3,  "s1_hold",   ex(HOLD, 1, 0, 0, 0, 0, 0));
    push(4,  "s1_wait",   ex(WAIT, 0, 0, 0, 0, 0, 0));
    push(9,  "s1_wait2",  ex(WAIT, 0, 0, 0, 0, 0, 0));
    push(10, "s1_stable", ex(STAB, 0, 0, 0, 0, 0, 0));
    push(17, "s1_stab_e", ex(STAB, 0, 0, 0, 0, 0, 0));
    push(18, "s1_run",    ex(RUN,  0, 1, 1, 0, 0, 0));
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) tick();
      while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h want=%h", e.tag, c, obs, e.v);
        end
      end
      if (bus.pll_rst === 1'b1 && c == prst_hi) prst_hi++;
      if (bus.sys_rst_n === 1'b1 && rise < 0) rise = c;
      if (c == 7) bus.pll_locked = 1'b1;
    end
    checks++;
    if (prst_hi !== 4) begin
      errors++;
      $display("FAIL s1_pll_rst_width got=%0d want=4", prst_hi);
    end
    checks++;
    if (rise < 16 || rise > 18) begin
      errors++;
      $display("FAIL s1_sys_rst_rise got=%0d want=17+/-1", rise);
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    do_reset();
    push(10, "s2_stable",  ex(STAB, 0, 0, 0, 0, 0, 0));
    push(14, "s2_pre_gl",  ex(STAB, 0, 0, 0, 0, 0, 0));
    push(15, "s2_wait",    ex(WAIT, 0, 0, 0, 0, 0, 0));
    push(16, "s2_restab",  ex(STAB, 0, 0, 0, 0, 0, 0));
    push(23, "s2_no_run",  ex(STAB, 0, 0, 0, 0, 0, 0));
    push(24, "s2_run",     ex(RUN,  0, 1, 1, 0, 0, 0));
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) tick();
      while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h want=%h", e.tag, c, obs, e.v);
        end
      end
      if (c == 7)  bus.pll_locked = 1'b1;
      if (c == 12) bus.pll_locked = 1'b0;
      if (c == 13) bus.pll_locked = 1'b1;
    end
  endtask

  task automatic test_lock_loss();
    exp_t e;
    push(2,  "s3_still_run", ex(RUN,  0, 1, 1, 0, 0, 0));
    push(3,  "s3_hold",      ex(HOLD, 1, 0, 0, 0, cnt(1), 0));
    push(6,  "s3_hold_end",  ex(HOLD, 1, 0, 0, 0, cnt(1), 0));
    push(7,  "s3_wait",      ex(WAIT, 0, 0, 0, 0, cnt(1), 0));
    push(8,  "s3_stable",    ex(STAB, 0, 0, 0, 0, cnt(1), 0));
    push(15, "s3_stab_e",    ex(STAB, 0, 0, 0, 0, cnt(1), 0));
    push(16, "s3_relock",    ex(RUN,  0, 1, 1, 0, cnt(1), 0));
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) tick();
      while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h want=%h", e.tag, c, obs, e.v);
        end
      end
      if (c == 0) bus.pll_locked = 1'b0;
      if (c == 1) bus.pll_locked = 1'b1;
    end
  endtask

  task automatic test_timeout_fault();
    exp_t e;
    do_reset();
    push(4,  "s4_wait",     ex(WAIT, 0, 0, 0, 0, 0, 0));
    push(23, "s4_wait_end", ex(WAIT, 0, 0, 0, 0, 0, 0));
    push(24, "s4_tmo1",     ex(HOLD, 1, 0, 0, 0, 0, cnt(1)));
    push(27, "s4_hold2",    ex(HOLD, 1, 0, 0, 0, 0, cnt(1)));
    push(28, "s4_wait2",    ex(WAIT, 0, 0, 0, 0, 0, cnt(1)));
    push(47, "s4_wait2_e",  ex(WAIT, 0, 0, 0, 0, 0, cnt(1)));
    push(48, "s4_fault",    ex(FLT,  1, 0, 0, 1, 0, cnt(2)));
    push(60, "s4_fault_hd", ex(FLT,  1, 0, 0, 1, 0, cnt(2)));
    push(61, "s4_restart",  ex(HOLD, 1, 0, 0, 0, 0, cnt(2)));
    push(65, "s4_wait3",    ex(WAIT, 0, 0, 0, 0, 0, cnt(2)));
    push(66, "s4_stable",   ex(STAB, 0, 0, 0, 0, 0, cnt(2)));
    push(73, "s4_stab_e",   ex(STAB, 0, 0, 0, 0, 0, cnt(2)));
    push(74, "s4_run",      ex(RUN,  0, 1, 1, 0, 0, cnt(2)));
    for (int c = 0; c <= 74; c++) begin
      if (c > 0) tick();
      while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h want=%h", e.tag, c, obs, e.v);
        end
      end
      if (c == 60) bus.restart = 1'b1;
      if (c == 61) begin
        bus.restart    = 1'b0;
        bus.pll_locked = 1'b1;
      end
    end
  endtask

  task automatic test_restart_priority();
    exp_t e;
    push(2,  "s5_run",     ex(RUN,  0, 1, 1, 0, 0, cnt(2)));
    push(3,  "s5_hold",    ex(HOLD, 1, 0, 0, 0, 0, cnt(2)));
    push(7,  "s5_wait",    ex(WAIT, 0, 0, 0, 0, 0, cnt(2)));
    push(8,  "s5_stable",  ex(STAB, 0, 0, 0, 0, 0, cnt(2)));
    push(16, "s5_run2",    ex(RUN,  0, 1, 1, 0, 0, cnt(2)));
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) tick();
      while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h want=%h", e.tag, c, obs, e.v);
        end
      end
      if (c == 0) bus.pll_locked = 1'b0;
      if (c == 1) bus.pll_locked = 1'b1;
      if (c == 2) bus.restart = 1'b1;
      if (c == 3) bus.restart = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    push(3,  "s6_hold",   ex(HOLD, 1, 0, 0, 0, cnt(1), cnt(2)));
    push(8,  "s6_stable", ex(STAB, 0, 0, 0, 0, cnt(1), cnt(2)));
    push(10, "s6_stab2",  ex(STAB, 0, 0, 0, 0, cnt(1), cnt(2)));
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) tick();
      while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h want=%h", e.tag, c, obs, e.v);
        end
      end
      if (c == 0) bus.pll_locked = 1'b0;
      if (c == 1) bus.pll_locked = 1'b1;
    end
    push(0, "s6_async_rst", ex(HOLD, 1, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    #2;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s got=%h want=%h", e.tag, obs, e.v);
    end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.pll_locked = 1'b0;
    bus.restart    = 1'b0;
    test_reset();
    test_normal_start();
    test_glitch();
    test_lock_loss();
    test_timeout_fault();
    test_restart_priority();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
